axil_host_initiator: RTL and testbench
======================================

Name: axil_host_initiator

Overview:
- AXI4-Lite initiator (master) that drives a 32-bit control/status slave port such as s00_axi/s01_axi on top_fpga.
- Converts a simple valid/ready command interface into single AXI4-Lite read or write transactions, one outstanding at a time.
- Returns response code and read data on a valid/ready response interface.
- Used in synthesizable host-side test harnesses and as the PL-side shell master; includes a response-timeout watchdog.

Parameters:
- C_M00_AXI_ADDR_WIDTH, 6, AXI address width.
- C_M00_AXI_DATA_WIDTH, 32, AXI data width (32 only).
- timeout_cycles_p, 1024, cycles allowed in response-wait states before timeout (≥2).

Ports:
- m00_axi_aclk  in  1  clock.
- m00_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_addr_i  in  ADDR  byte address.
- cmd_data_i  in  DATA  write data.
- cmd_wstrb_i  in  DATA/8  write strobes.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_data_o  out  DATA  read data; 0 for writes.
- resp_code_o  out  2  BRESP/RRESP value.
- resp_timeout_o  out  1  response generated by watchdog.
- m00_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR/3/1/1  write address channel.
- m00_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA/DATA/8/1/1  write data channel.
- m00_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m00_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR/3/1/1  read address channel.
- m00_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA/2/1/1  read data channel.

Behaviour:
- Reset (async assert): state=IDLE.
  - All AXI valid/ready outputs, resp_v_o, resp_timeout_o and counter reset to 0.
  - resp_data_o, resp_code_o and awaddr/araddr/wdata/wstrb reset to 0.
  - awprot and arprot are constant 3'b000.
- FSM states:
  - IDLE: cmd_ready_o=1. Accept on the handshake cycle, register address/data/strb.
    - Write: go to WR_ADDR_DATA with aw_pend=w_pend=1.
    - Read: go to RD_ADDR.
  - WR_ADDR_DATA: awvalid=aw_pend and wvalid=w_pend, both registered (visible the cycle after accept).
    - Each pend clears independently on its own handshake; either order, or the same cycle.
    - When both clear, go to WAIT_B. Valids are never withdrawn before their handshake.
  - RD_ADDR: arvalid=1 until arready, then go to WAIT_R.
  - WAIT_B / WAIT_R: bready/rready=1. Counter increments each cycle in these states.
    - On bvalid/rvalid: capture resp (and rdata for reads), clear counter, go to RESP.
    - If the counter reaches timeout_cycles_p-1 with no response: resp_code_o=2'b10 (SLVERR), resp_timeout_o=1, resp_data_o=0, go to RESP_DRAIN.
  - RESP: resp_v_o=1, outputs held stable. On resp_ready_i, go to IDLE.
  - RESP_DRAIN: resp_v_o=1 and bready/rready stay 1 to absorb the late beat.
    - A late beat is discarded and sets drained=1.
    - Return to IDLE when resp consumed and drained (both may occur in the same cycle).
    - If resp is consumed first, stay in DRAIN_ONLY with resp_v_o=0 until the beat arrives.
- Latency:
  - Command accept to awvalid/arvalid: 1 cycle.
  - B/R handshake at cycle N to resp_v_o=1 at N+1.
  - Minimum write (all readies high) is accept to resp_v_o in 3 cycles; minimum read is also 3 cycles.
- cmd_ready_o=0 in all states except IDLE. No new command can be accepted in the resp_v_o handshake cycle.
- bready/rready are 0 outside WAIT/DRAIN states. Spurious bvalid/rvalid are ignored.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF, wstrb=0xF; awready=wready=1 same cycle; bresp=0 after 2 cycles -> one AW and one W beat with matching values; resp_v_o at accept+5, resp_code_o=0, resp_data_o=0.
- Write with wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid held 3 more cycles until awready, exactly one B accepted.
- Read addr=0x24; slave returns rdata=0x12345678, rresp=2'b10 -> resp_data_o=0x12345678, resp_code_o=2, resp_timeout_o=0.
- Read, timeout_cycles_p=16, rvalid withheld 40 cycles -> resp_v_o with timeout=1, code=2 after 16 WAIT_R cycles; late R beat absorbed; next command accepted only after drain.
- resp_ready_i held low 10 cycles after a read response -> resp_v_o and data stable, cmd_ready_o=0 throughout.
- m00_axi_aresetn asserted while awvalid=1 mid-write -> all valids 0 immediately (same cycle, async); after release, cmd_ready_o=1 and a fresh read completes normally.

Source files
------------

// File: rtl/axil_host_initiator.sv
// -----------------------------------------------------------------------------
// axil_host_initiator
//
// AXI4-Lite initiator that turns a valid/ready command stream into single
// read or write transactions, one outstanding at a time, and returns the
// response on a valid/ready response stream. A watchdog bounds the wait for
// B/R; on expiry it reports SLVERR with resp_timeout_o=1 and quietly drains
// the late beat before accepting the next command.
//
// Ports:
//   m00_axi_aclk / m00_axi_aresetn     clock, async active-low reset
//   cmd_v_i / cmd_ready_o              command handshake
//   cmd_we_i, cmd_addr_i, cmd_data_i, cmd_wstrb_i   command payload
//   resp_v_o / resp_ready_i            response handshake
//   resp_data_o, resp_code_o, resp_timeout_o       response payload
//   m00_axi_aw*, m00_axi_w*, m00_axi_b*, m00_axi_ar*, m00_axi_r*
//                                      AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_host_initiator #(
  parameter int C_M00_AXI_ADDR_WIDTH = 6,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int timeout_cycles_p     = 1024
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_aresetn,
  input  logic                                cmd_v_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_we_i,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_data_i,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb_i,
  output logic                                resp_v_o,
  input  logic                                resp_ready_i,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     resp_data_o,
  output logic [1:0]                          resp_code_o,
  output logic                                resp_timeout_o,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int CW = $clog2(timeout_cycles_p);
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles_p - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_RD_ADDR,
    S_WAIT_B,
    S_WAIT_R,
    S_RESP,
    S_RESP_DRAIN,
    S_DRAIN_ONLY
  } state_e;

  state_e          state_q, state_d;
  logic            aw_pend_q, aw_pend_d;
  logic            w_pend_q, w_pend_d;
  logic            is_wr_q, is_wr_d;
  logic            drained_q, drained_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic [1:0]      resp_code_q, resp_code_d;
  logic            resp_timeout_q, resp_timeout_d;

  logic            draining;
  logic            beat;

  // Drain states keep the ready of whichever channel the timed-out
  // transaction used, so the late beat is swallowed on the right channel.
  assign draining        = (state_q == S_RESP_DRAIN) || (state_q == S_DRAIN_ONLY);
  assign m00_axi_bready  = (state_q == S_WAIT_B) || (draining && is_wr_q);
  assign m00_axi_rready  = (state_q == S_WAIT_R) || (draining && !is_wr_q);
  // Valids outside the matching ready window never count, so spurious
  // bvalid/rvalid are ignored.
  assign beat = is_wr_q ? (m00_axi_bvalid && m00_axi_bready)
                        : (m00_axi_rvalid && m00_axi_rready);

  assign cmd_ready_o     = (state_q == S_IDLE);
  assign resp_v_o        = (state_q == S_RESP) || (state_q == S_RESP_DRAIN);
  assign resp_data_o     = resp_data_q;
  assign resp_code_o     = resp_code_q;
  assign resp_timeout_o  = resp_timeout_q;

  assign m00_axi_awaddr  = awaddr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = aw_pend_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_wvalid  = w_pend_q;
  assign m00_axi_araddr  = araddr_q;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = (state_q == S_RD_ADDR);

  always_comb begin
    // NOTE: every variable written here gets its hold value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    aw_pend_d      = aw_pend_q;
    w_pend_d       = w_pend_q;
    is_wr_d        = is_wr_q;
    drained_d      = drained_q;
    cnt_d          = cnt_q;
    awaddr_d       = awaddr_q;
    araddr_d       = araddr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    resp_data_d    = resp_data_q;
    resp_code_d    = resp_code_q;
    resp_timeout_d = resp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_v_i) begin
          is_wr_d = cmd_we_i;
          if (cmd_we_i) begin
            awaddr_d  = cmd_addr_i;
            wdata_d   = cmd_data_i;
            wstrb_d   = cmd_wstrb_i;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_ADDR_DATA;
          end else begin
            araddr_d  = cmd_addr_i;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR_ADDR_DATA: begin
        // The pends are the valids, so each clears only on its own handshake.
        aw_pend_d = aw_pend_q && !m00_axi_awready;
        w_pend_d  = w_pend_q && !m00_axi_wready;
        if (!aw_pend_d && !w_pend_d) state_d = S_WAIT_B;
      end
      S_RD_ADDR: begin
        if (m00_axi_arready) state_d = S_WAIT_R;
      end
      S_WAIT_B, S_WAIT_R: begin
        if (beat) begin
          resp_code_d    = is_wr_q ? m00_axi_bresp : m00_axi_rresp;
          resp_data_d    = is_wr_q ? '0 : m00_axi_rdata;
          resp_timeout_d = 1'b0;
          cnt_d          = '0;
          state_d        = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // A response on the last allowed cycle still wins over the timeout.
          resp_code_d    = 2'b10;
          resp_data_d    = '0;
          resp_timeout_d = 1'b1;
          cnt_d          = '0;
          drained_d      = 1'b0;
          state_d        = S_RESP_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      S_RESP_DRAIN: begin
        drained_d = drained_q || beat;
        if (resp_ready_i) state_d = drained_d ? S_IDLE : S_DRAIN_ONLY;
      end
      S_DRAIN_ONLY: begin
        if (beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q        <= S_IDLE;
      aw_pend_q      <= 1'b0;
      w_pend_q       <= 1'b0;
      is_wr_q        <= 1'b0;
      drained_q      <= 1'b0;
      cnt_q          <= '0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      resp_data_q    <= '0;
      resp_code_q    <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      aw_pend_q      <= aw_pend_d;
      w_pend_q       <= w_pend_d;
      is_wr_q        <= is_wr_d;
      drained_q      <= drained_d;
      cnt_q          <= cnt_d;
      awaddr_q       <= awaddr_d;
      araddr_q       <= araddr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      resp_data_q    <= resp_data_d;
      resp_code_q    <= resp_code_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

endmodule

// File: tb/tb_axil_host_initiator.sv
// -----------------------------------------------------------------------------
// tb_axil_host_initiator
//
// Directed bench for axil_host_initiator with a latency-programmable AXI4-Lite
// slave, a transaction-level response/latency model, and a compare process
// that checks every meaningful output on every cycle.
// -----------------------------------------------------------------------------
module tb_axil_host_initiator;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_v, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [3:0]    cmd_wstrb;
  logic          resp_v, resp_ready, resp_timeout;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_code;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_host_initiator #(
    .C_M00_AXI_ADDR_WIDTH(AW),
    .C_M00_AXI_DATA_WIDTH(DW),
    .timeout_cycles_p(T)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_wstrb_i(cmd_wstrb),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_code_o(resp_code), .resp_timeout_o(resp_timeout),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- slave configuration and bookkeeping ----------------
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit          got_aw, got_w, b_owed, r_owed;
  int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
  int          aw_only_cycles = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_wstrb;

  // Slave: each ready rises after <lat> cycles of its valid; B/R valid rises
  // <lat> cycles after the request is complete and holds until accepted.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    got_aw = 0; got_w = 0; b_owed = 0; r_owed = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        got_aw = 0; got_w = 0; b_owed = 0; r_owed = 0;
      end else begin
        if (aw_hs) begin awready = 0; aw_hs = 0; end
        if (w_hs)  begin wready = 0;  w_hs = 0;  end
        if (ar_hs) begin arready = 0; ar_hs = 0; end
        if (b_hs)  begin bvalid = 0; b_hs = 0; b_owed = 0; end
        if (r_hs)  begin rvalid = 0; r_hs = 0; r_owed = 0; end
        if (b_owed && !bvalid) begin
          if (b_cnt >= b_lat) begin bvalid = 1; bresp = bresp_cfg; end else b_cnt++;
        end
        if (bvalid && bready) begin b_hs = 1; b_beats++; end
        if (r_owed && !rvalid) begin
          if (r_cnt >= r_lat) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
          else r_cnt++;
        end
        if (rvalid && rready) begin r_hs = 1; r_beats++; end
        if (awvalid && !wvalid) aw_only_cycles++;
        if (awvalid) begin if (aw_cnt >= aw_lat) awready = 1; else aw_cnt++; end
        if (awvalid && awready) begin
          aw_hs = 1; aw_beats++; cap_awaddr = awaddr; got_aw = 1; aw_cnt = 0;
        end
        if (wvalid) begin if (w_cnt >= w_lat) wready = 1; else w_cnt++; end
        if (wvalid && wready) begin
          w_hs = 1; w_beats++; cap_wdata = wdata; cap_wstrb = wstrb; got_w = 1; w_cnt = 0;
        end
        if (arvalid) begin if (ar_cnt >= ar_lat) arready = 1; else ar_cnt++; end
        if (arvalid && arready) begin
          ar_hs = 1; ar_beats++; cap_araddr = araddr; ar_cnt = 0; r_owed = 1; r_cnt = 0;
        end
        if (got_aw && got_w) begin got_aw = 0; got_w = 0; b_owed = 1; b_cnt = 0; end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata, exp_data;
  logic [3:0]    exp_wstrb;
  logic [1:0]    exp_code;
  logic          exp_to;
  int            exp_lat;

  // Response contents and accept-to-resp_v latency from the slave settings:
  // one cycle to the address phase, the address phase itself, the wait for
  // B/R (capped at T cycles), one cycle to resp_v.
  task automatic set_exp(input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    int rl, ph;
    exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
    rl = we ? b_lat : r_lat;
    ph = we ? ((aw_lat > w_lat) ? aw_lat : w_lat) : ar_lat;
    if (rl >= T) begin
      exp_data = 0; exp_code = 2'b10; exp_to = 1;
    end else begin
      exp_data = we ? 32'h0 : rdata_cfg;
      exp_code = we ? bresp_cfg : rresp_cfg;
      exp_to   = 0;
    end
    exp_lat = ph + 3 + ((rl >= T) ? (T - 1) : rl);
  endtask

  // Per-cycle comparison of every output that carries meaning this cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (resp_v) begin
        check("resp_data", resp_data, exp_data);
        check("resp_code", {30'b0, resp_code}, {30'b0, exp_code});
        check("resp_timeout", {31'b0, resp_timeout}, {31'b0, exp_to});
        check("cmd_ready_in_resp", {31'b0, cmd_ready}, 32'h0);
      end
      if (awvalid) begin
        check("awaddr", {26'b0, awaddr}, {26'b0, exp_addr});
        check("awprot", {29'b0, awprot}, 32'h0);
      end
      if (wvalid) begin
        check("wdata", wdata, exp_wdata);
        check("wstrb", {28'b0, wstrb}, {28'b0, exp_wstrb});
      end
      if (arvalid) begin
        check("araddr", {26'b0, araddr}, {26'b0, exp_addr});
        check("arprot", {29'b0, arprot}, 32'h0);
      end
    end
  end

  // ---------------- command / response drivers ----------------
  // Called at a falling edge; returns at the falling edge where resp_v is seen.
  task automatic do_cmd(input bit we, input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat);
    int n;
    set_exp(we, addr, data, strb);
    cmd_v = 1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", {31'b0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_v = 0;
    lat = 1;
    while (!resp_v && lat < 200) begin @(negedge clk); lat++; end
    check("resp_v_seen", {31'b0, resp_v}, 32'h1);
    check("latency", lat, exp_lat);
  endtask

  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("resp_hold", {31'b0, resp_v}, 32'h1);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("resp_v_after_consume", {31'b0, resp_v}, 32'h0);
  endtask

  task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
    aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ab, wb, bb, rb, ao;
    rst_n = 0; cmd_v = 0; cmd_we = 0; cmd_addr = 0; cmd_data = 0; cmd_wstrb = 0;
    resp_ready = 0;
    set_lat(0, 0, 0, 0, 0);
    bresp_cfg = 0; rresp_cfg = 0; rdata_cfg = 0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_awvalid", {31'b0, awvalid}, 0);
    check("rst_wvalid", {31'b0, wvalid}, 0);
    check("rst_arvalid", {31'b0, arvalid}, 0);
    check("rst_bready", {31'b0, bready}, 0);
    check("rst_rready", {31'b0, rready}, 0);
    check("rst_resp_v", {31'b0, resp_v}, 0);
    check("rst_timeout", {31'b0, resp_timeout}, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_code", {30'b0, resp_code}, 0);
    check("rst_awaddr", {26'b0, awaddr}, 0);
    check("rst_araddr", {26'b0, araddr}, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", {28'b0, wstrb}, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_cmd_ready", {31'b0, cmd_ready}, 1);

    // Write 0x10 <= DEADBEEF, AW/W same cycle, B two cycles late
    set_lat(0, 0, 2, 0, 0); bresp_cfg = 2'b00;
    ab = aw_beats; wb = w_beats; bb = b_beats;
    do_cmd(1, 6'h10, 32'hDEADBEEF, 4'hF, lat);
    check("wr1_latency_lit", lat, 5);
    check("wr1_aw_beats", aw_beats - ab, 1);
    check("wr1_w_beats", w_beats - wb, 1);
    check("wr1_awaddr_lit", {26'b0, cap_awaddr}, 32'h10);
    check("wr1_wdata_lit", cap_wdata, 32'hDEADBEEF);
    check("wr1_wstrb_lit", {28'b0, cap_wstrb}, 32'hF);
    check("wr1_code_lit", {30'b0, resp_code}, 0);
    check("wr1_data_lit", resp_data, 0);
    consume(0);
    check("wr1_b_beats", b_beats - bb, 1);

    // Minimum-latency write and read
    set_lat(0, 0, 0, 0, 0); bresp_cfg = 2'b01;
    do_cmd(1, 6'h3C, 32'hA5A50F0F, 4'h5, lat);
    check("wr_min_latency_lit", lat, 3);
    consume(0);
    rdata_cfg = 32'hCAFEF00D; rresp_cfg = 2'b00;
    do_cmd(0, 6'h08, 32'h0, 4'h0, lat);
    check("rd_min_latency_lit", lat, 3);
    consume(0);

    // W accepted three cycles before AW
    set_lat(3, 0, 0, 0, 0); bresp_cfg = 2'b00;
    ab = aw_beats; wb = w_beats; bb = b_beats; ao = aw_only_cycles;
    do_cmd(1, 6'h20, 32'h01020304, 4'h3, lat);
    check("wr2_latency_lit", lat, 6);
    check("wr2_aw_only_cycles", aw_only_cycles - ao, 3);
    check("wr2_aw_beats", aw_beats - ab, 1);
    check("wr2_w_beats", w_beats - wb, 1);
    consume(0);
    check("wr2_b_beats", b_beats - bb, 1);

    // AW accepted before W
    set_lat(0, 2, 1, 0, 0); bresp_cfg = 2'b11;
    do_cmd(1, 6'h04, 32'h89ABCDEF, 4'hC, lat);
    consume(0);

    // Read 0x24 with SLVERR data, then a 10-cycle stall on resp_ready
    set_lat(0, 0, 0, 0, 1); rdata_cfg = 32'h12345678; rresp_cfg = 2'b10;
    do_cmd(0, 6'h24, 32'h0, 4'h0, lat);
    check("rd1_data_lit", resp_data, 32'h12345678);
    check("rd1_code_lit", {30'b0, resp_code}, 2);
    check("rd1_timeout_lit", {31'b0, resp_timeout}, 0);
    consume(10);

    // Response on the last allowed wait cycle is not a timeout
    set_lat(0, 0, 0, 0, T - 1); rdata_cfg = 32'h0BADCAFE; rresp_cfg = 2'b00;
    do_cmd(0, 6'h18, 32'h0, 4'h0, lat);
    check("rd_edge_latency_lit", lat, 18);
    check("rd_edge_timeout_lit", {31'b0, resp_timeout}, 0);
    consume(0);

    // Timeout: R withheld 40 cycles, late beat drained before the next command
    set_lat(0, 0, 0, 0, 40); rdata_cfg = 32'hFFFF0000; rresp_cfg = 2'b00;
    rb = r_beats;
    do_cmd(0, 6'h30, 32'h0, 4'h0, lat);
    check("rd_to_latency_lit", lat, 18);
    check("rd_to_timeout_lit", {31'b0, resp_timeout}, 1);
    check("rd_to_code_lit", {30'b0, resp_code}, 2);
    check("rd_to_data_lit", resp_data, 0);
    consume(1);
    check("rd_to_no_beat_yet", r_beats - rb, 0);
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    check("drain_before_ready", r_beats - rb, 1);
    check("ready_after_drain", {31'b0, cmd_ready}, 1);
    set_lat(0, 0, 0, 0, 0); rdata_cfg = 32'h55AA33CC; rresp_cfg = 2'b01;
    do_cmd(0, 6'h0C, 32'h0, 4'h0, lat);
    consume(0);

    // Asynchronous reset in the middle of a write
    set_lat(100, 100, 0, 0, 0);
    set_exp(1, 6'h2C, 32'h77777777, 4'hF);
    cmd_v = 1; cmd_we = 1; cmd_addr = 6'h2C; cmd_data = 32'h77777777; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_v = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_awvalid", {31'b0, awvalid}, 1);
    #2 rst_n = 0;
    #1;
    check("arst_awvalid", {31'b0, awvalid}, 0);
    check("arst_wvalid", {31'b0, wvalid}, 0);
    check("arst_arvalid", {31'b0, arvalid}, 0);
    check("arst_resp_v", {31'b0, resp_v}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    set_lat(0, 0, 0, 0, 0); rdata_cfg = 32'h600DF00D; rresp_cfg = 2'b00;
    do_cmd(0, 6'h14, 32'h0, 4'h0, lat);
    check("post_rst_rd_latency_lit", lat, 3);
    check("post_rst_rd_data_lit", resp_data, 32'h600DF00D);
    consume(0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
